// File: rtl/au_div_seq.sv
// au_div_seq: sequential sign-magnitude fixed-point divider and reciprocal unit.
// Radix-2 restoring division, one quotient bit per clock, start/busy/done handshake.
module au_div_seq #(
    parameter int W     = 24,
    parameter int FRAC  = 14,
    parameter int ROUND = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] s_in,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         dz,
    output logic         ovf
);

    localparam int MAG  = W - 1;
    localparam int ITER = W - 1 + FRAC;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [CW-1:0]  CNT_LAST = CW'(ITER - 1);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [MAG-1:0] MAG_ONES = {MAG{1'b1}};
    localparam logic [MAG-1:0] MAG_ZERO = {MAG{1'b0}};
    localparam logic [MAG-1:0] ONE_FX   = {{(MAG-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [ITER-1:0] DVD_ZERO = {ITER{1'b0}};
    localparam logic           ROUND_EN = (ROUND != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic [MAG-1:0]  r_rem;
    logic [ITER-1:0] r_dvd;
    logic [ITER-1:0] r_quo;
    logic [MAG-1:0]  r_div;
    logic            r_sign;
    logic            r_dz_pend;
    logic [W-1:0]    r_result;
    logic            r_done;
    logic            r_busy;
    logic            r_dz;
    logic            r_ovf;

    logic [MAG-1:0]  w_r_mag;
    logic            w_r_sign;
    logic [MAG-1:0]  w_s_mag;
    logic            w_s_zero;
    logic [MAG:0]    w_trial;
    logic            w_ge;
    logic [MAG-1:0]  w_sub;
    logic [MAG-1:0]  w_rem_nxt;
    logic [FRAC-1:0] w_q_hi;
    logic            w_rnd;
    logic [MAG:0]    w_q_sum;
    logic            w_sat;
    logic [MAG-1:0]  w_mag_fin;
    logic            w_sign_fin;

    // Operand decode: reciprocal mode substitutes +1.0 for the dividend.
    assign w_r_mag  = mode ? ONE_FX : r_in[MAG-1:0];
    assign w_r_sign = mode ? 1'b0 : r_in[W-1];
    assign w_s_mag  = s_in[MAG-1:0];
    assign w_s_zero = (w_s_mag == MAG_ZERO);

    // The remainder stays below the divisor, so the difference fits in MAG bits.
    assign w_trial   = {r_rem, r_dvd[ITER-1]};
    assign w_ge      = (w_trial >= {1'b0, r_div});
    assign w_sub     = w_trial[MAG-1:0] - r_div;
    assign w_rem_nxt = w_ge ? w_sub : w_trial[MAG-1:0];

    // Final rounding and saturation; the upper FRAC quotient bits only ever signal overflow.
    assign w_q_hi     = r_quo[ITER-1:MAG];
    assign w_rnd      = ROUND_EN & ({r_rem, 1'b0} >= {1'b0, r_div});
    assign w_q_sum    = {1'b0, r_quo[MAG-1:0]} + {MAG_ZERO, w_rnd};
    assign w_sat      = (|w_q_hi) | w_q_sum[MAG];
    assign w_mag_fin  = (r_dz_pend | w_sat) ? MAG_ONES : w_q_sum[MAG-1:0];
    assign w_sign_fin = r_sign & (w_mag_fin != MAG_ZERO);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only looked at from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_s_zero) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_state_nxt = ST_CALC;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= CNT_ZERO;
            r_rem     <= MAG_ZERO;
            r_dvd     <= DVD_ZERO;
            r_quo     <= DVD_ZERO;
            r_div     <= MAG_ZERO;
            r_sign    <= 1'b0;
            r_dz_pend <= 1'b0;
            r_result  <= {W{1'b0}};
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_div     <= w_s_mag;
                        r_sign    <= w_r_sign ^ s_in[W-1];
                        r_dvd     <= {w_r_mag, {FRAC{1'b0}}};
                        r_quo     <= DVD_ZERO;
                        r_rem     <= MAG_ZERO;
                        r_cnt     <= CNT_ZERO;
                        r_dz_pend <= w_s_zero;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[ITER-2:0], 1'b0};
                    r_quo <= {r_quo[ITER-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_ONE;
                end
                ST_FIN: begin
                    r_result <= {w_sign_fin, w_mag_fin};
                    r_dz     <= r_dz_pend;
                    r_ovf    <= w_sat & ~r_dz_pend;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;
    assign dz     = r_dz;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_au_div_seq.sv
// Testbench for au_div_seq: scoreboard of expected results, one task per scenario.
// A ROUND=1 and a ROUND=0 instance share the same stimulus.
module tb_au_div_seq;

    localparam int W    = 24;
    localparam int FRAC = 14;
    localparam int LAT  = W - 1 + FRAC + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [W-1:0]  r_in;
    logic [W-1:0]  s_in;
    logic [W-1:0]  result, result_t;
    logic          done, done_t, busy, busy_t, dz, dz_t, ovf, ovf_t;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         dz;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_t[$];

    au_div_seq #(.W(W), .FRAC(FRAC), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .r_in(r_in), .s_in(s_in),
        .result(result), .done(done), .busy(busy), .dz(dz), .ovf(ovf)
    );

    au_div_seq #(.W(W), .FRAC(FRAC), .ROUND(0)) dut_t (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .r_in(r_in), .s_in(s_in),
        .result(result_t), .done(done_t), .busy(busy_t), .dz(dz_t), .ovf(ovf_t)
    );

    always #5 clk = ~clk;

    // Reference: exact integer division of the widened magnitudes.
    function automatic exp_t model(input logic md, input logic [W-1:0] r, input logic [W-1:0] s,
                                   input bit rnd);
        logic [63:0] rm, sm, q, rem;
        logic        sgn;
        exp_t        e;
        rm  = md ? (64'd1 << FRAC) : {41'd0, r[W-2:0]};
        sm  = {41'd0, s[W-2:0]};
        sgn = (md ? 1'b0 : r[W-1]) ^ s[W-1];
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (sm == 64'd0) begin
            e.dz  = 1'b1;
            e.res = {sgn, 23'h7FFFFF};
        end else begin
            q   = (rm << FRAC) / sm;
            rem = (rm << FRAC) % sm;
            if (rnd && (2 * rem >= sm)) q = q + 64'd1;
            if (q > 64'h7FFFFF) begin
                e.ovf = 1'b1;
                q     = 64'h7FFFFF;
            end
            e.res = {sgn & (q != 64'd0), q[22:0]};
        end
        return e;
    endfunction

    // Drives one start at the next edge; operands are scrambled afterwards.
    task automatic launch(input logic md, input logic [W-1:0] r, input logic [W-1:0] s, input bit hold);
        mode  = md;
        r_in  = r;
        s_in  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        r_in  = 24'($urandom);
        s_in  = 24'($urandom);
        mode  = ~md;
    endtask

    // Waits for done (bounded); reports latency in edges after the start edge.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = (busy === 1'b1);
        for (int i = 1; i <= 100 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) lat = i;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; r_in = 24'h0; s_in = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({result, done, busy, dz, ovf} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset: got %h d%b b%b dz%b ov%b, expected all zero", result, done, busy, dz, ovf);
        end
        n_checks++;
        if ({result_t, done_t, busy_t, dz_t, ovf_t} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_t: got %h d%b b%b, expected all zero", result_t, done_t, busy_t);
        end
        rst = 1'b0;
    endtask

    task automatic test_recip();
        logic [W-1:0] s_tab [4];
        logic [W-1:0] r1_tab[4];
        logic [W-1:0] r0_tab[4];
        exp_t e, et;
        int   lat;
        bit   bok;
        s_tab  = '{24'h008000, 24'h810000, 24'h00C000, 24'h018000};
        r1_tab = '{24'h002000, 24'h801000, 24'h001555, 24'h000AAB};
        r0_tab = '{24'h002000, 24'h801000, 24'h001555, 24'h000AAA};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({r1_tab[i], 1'b0, 1'b0});
            sb_t.push_back({r0_tab[i], 1'b0, 1'b0});
            launch(1'b1, 24'h123456, s_tab[i], 1'b0);
            wait_done(lat, bok);
            e  = sb_q.pop_front();
            et = sb_t.pop_front();
            n_checks++;
            if ({result, dz, ovf} !== e) begin
                n_fail++;
                $display("FAIL recip[%0d]: got %h dz%b ov%b, expected %h dz%b ov%b", i, result, dz, ovf, e.res, e.dz, e.ovf);
            end
            n_checks++;
            if ({result_t, dz_t, ovf_t} !== et) begin
                n_fail++;
                $display("FAIL recip_trunc[%0d]: got %h, expected %h", i, result_t, et.res);
            end
            n_checks++;
            if (lat !== LAT || !bok) begin
                n_fail++;
                $display("FAIL recip_latency[%0d]: got %0d busy_ok=%b, expected %0d busy_ok=1", i, lat, bok, LAT);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL recip_idle[%0d]: got done=%b busy=%b, expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_divide();
        logic [W-1:0] r_tab[5];
        logic [W-1:0] s_tab[5];
        logic [W-1:0] q_tab[5];
        logic         o_tab[5];
        exp_t e, et;
        int   lat;
        bit   bok;
        r_tab = '{24'h400000, 24'h01C000, 24'h800000, 24'h400000, 24'h400000};
        s_tab = '{24'h002000, 24'h008000, 24'h004000, 24'h802000, 24'h804000};
        q_tab = '{24'h7FFFFF, 24'h00E000, 24'h000000, 24'hFFFFFF, 24'hC00000};
        o_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back({q_tab[i], 1'b0, o_tab[i]});
            sb_t.push_back({q_tab[i], 1'b0, o_tab[i]});
            launch(1'b0, r_tab[i], s_tab[i], 1'b0);
            wait_done(lat, bok);
            e  = sb_q.pop_front();
            et = sb_t.pop_front();
            n_checks++;
            if ({result, dz, ovf} !== e || lat !== LAT) begin
                n_fail++;
                $display("FAIL divide[%0d]: got %h dz%b ov%b lat %0d, expected %h dz%b ov%b lat %0d",
                         i, result, dz, ovf, lat, e.res, e.dz, e.ovf, LAT);
            end
            n_checks++;
            if ({result_t, dz_t, ovf_t} !== et) begin
                n_fail++;
                $display("FAIL divide_trunc[%0d]: got %h ov%b, expected %h ov%b", i, result_t, ovf_t, et.res, et.ovf);
            end
        end
    endtask

    task automatic test_div_zero();
        logic         m_tab[3];
        logic [W-1:0] r_tab[3];
        logic [W-1:0] s_tab[3];
        logic [W-1:0] q_tab[3];
        logic         z_tab[3];
        int           l_tab[3];
        exp_t e;
        int   lat;
        bit   bok;
        m_tab = '{1'b0, 1'b1, 1'b0};
        r_tab = '{24'h804000, 24'h000000, 24'h01C000};
        s_tab = '{24'h000000, 24'h800000, 24'h008000};
        q_tab = '{24'hFFFFFF, 24'hFFFFFF, 24'h00E000};
        z_tab = '{1'b1, 1'b1, 1'b0};
        l_tab = '{1, 1, LAT};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back({q_tab[i], z_tab[i], 1'b0});
            launch(m_tab[i], r_tab[i], s_tab[i], 1'b0);
            wait_done(lat, bok);
            e = sb_q.pop_front();
            n_checks++;
            if ({result, dz, ovf} !== e) begin
                n_fail++;
                $display("FAIL dz[%0d]: got %h dz%b ov%b, expected %h dz%b ov%b", i, result, dz, ovf, e.res, e.dz, e.ovf);
            end
            n_checks++;
            if (lat !== l_tab[i] || !bok) begin
                n_fail++;
                $display("FAIL dz_latency[%0d]: got %0d busy_ok=%b, expected %0d", i, lat, bok, l_tab[i]);
            end
            n_checks++;
            if (dz_t !== z_tab[i]) begin
                n_fail++;
                $display("FAIL dz_trunc[%0d]: got %b, expected %b", i, dz_t, z_tab[i]);
            end
        end
    endtask

    task automatic test_hold_start();
        exp_t e;
        int   lat;
        bit   bok;
        sb_q.push_back({24'h00E000, 1'b0, 1'b0});
        launch(1'b0, 24'h01C000, 24'h008000, 1'b1);
        wait_done(lat, bok);
        start = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({result, dz, ovf} !== e || lat !== LAT || !bok) begin
            n_fail++;
            $display("FAIL hold_start: got %h lat %0d busy_ok=%b, expected %h lat %0d", result, lat, bok, e.res, LAT);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_start_idle: got done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   bok;
        sb_q.push_back({24'h002000, 1'b0, 1'b0});
        sb_q.push_back({24'h00E000, 1'b0, 1'b0});
        launch(1'b1, 24'h0, 24'h008000, 1'b0);
        wait_done(lat, bok);
        e = sb_q.pop_front();
        n_checks++;
        if ({result, dz, ovf} !== e || lat !== LAT) begin
            n_fail++;
            $display("FAIL b2b_first: got %h lat %0d, expected %h lat %0d", result, lat, e.res, LAT);
        end
        launch(1'b0, 24'h01C000, 24'h008000, 1'b0);
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b, expected 1 0", busy, done);
        end
        wait_done(lat, bok);
        e = sb_q.pop_front();
        n_checks++;
        if ({result, dz, ovf} !== e || lat !== LAT || !bok) begin
            n_fail++;
            $display("FAIL b2b_second: got %h lat %0d, expected %h lat %0d", result, lat, e.res, LAT);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        bit   bok;
        bit   saw;
        launch(1'b1, 24'h0, 24'h00C000, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({result, done, busy, dz, ovf} !== 28'h0 || {result_t, busy_t} !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h d%b b%b dz%b ov%b, expected all zero", result, done, busy, dz, ovf);
        end
        rst = 1'b0;
        saw = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done || done_t || busy) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got activity=%b, expected 0", saw);
        end
        sb_q.push_back({24'h001555, 1'b0, 1'b0});
        launch(1'b1, 24'h0, 24'h00C000, 1'b0);
        wait_done(lat, bok);
        e = sb_q.pop_front();
        n_checks++;
        if ({result, dz, ovf} !== e || lat !== LAT || !bok) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got %h lat %0d, expected %h lat %0d", result, lat, e.res, LAT);
        end
    endtask

    task automatic test_random();
        exp_t         e, et;
        int           lat;
        bit           bok;
        logic         md;
        logic [W-1:0] r, s;
        for (int i = 0; i < 24; i++) begin
            md = 1'($urandom_range(0, 1));
            r  = 24'($urandom);
            r  = {r[W-1], 23'(r[W-2:0] >> $urandom_range(0, 22))};
            s  = 24'($urandom);
            s  = {s[W-1], 23'(s[W-2:0] >> $urandom_range(0, 22))};
            if (i % 8 == 3) s[W-2:0] = 23'h0;
            sb_q.push_back(model(md, r, s, 1'b1));
            sb_t.push_back(model(md, r, s, 1'b0));
            launch(md, r, s, 1'b0);
            wait_done(lat, bok);
            e  = sb_q.pop_front();
            et = sb_t.pop_front();
            n_checks++;
            if ({result, dz, ovf} !== e || lat !== (e.dz ? 1 : LAT)) begin
                n_fail++;
                $display("FAIL random[%0d] m%b r=%h s=%h: got %h dz%b ov%b lat %0d, expected %h dz%b ov%b",
                         i, md, r, s, result, dz, ovf, lat, e.res, e.dz, e.ovf);
            end
            n_checks++;
            if ({result_t, dz_t, ovf_t} !== et) begin
                n_fail++;
                $display("FAIL random_trunc[%0d] m%b r=%h s=%h: got %h, expected %h", i, md, r, s, result_t, et.res);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        r_in  = 24'h0;
        s_in  = 24'h0;
        test_reset();
        test_recip();
        test_divide();
        test_div_zero();
        test_hold_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
